// File: rtl/branch_predict_unit_if.sv
// Fetch/resolve bus of the branch predictor.
// slave = predictor side, master = pipeline side; stats ports exist with BPU_STATS_EN.
interface branch_predict_unit_if #(
  parameter int PC_W = 9
);
  logic [PC_W-1:0] if_pc_i;
  logic            if_pred_taken_o;
  logic [31:0]     if_pred_target_o;
  logic            ex_valid_i;
  logic [PC_W-1:0] ex_pc_i;
  logic [31:0]     ex_imm_i;
  logic            ex_branch_i;
  logic [31:0]     ex_alu_result_i;
  logic            ex_pred_taken_i;
  logic [31:0]     ex_pred_target_i;
  logic [31:0]     pc_imm_o;
  logic [31:0]     pc_four_o;
  logic            redirect_o;
  logic [31:0]     redirect_pc_o;
`ifdef BPU_STATS_EN
  logic [31:0]     stat_branches_o;
  logic [31:0]     stat_mispred_o;
`endif

  modport slave (
    input  if_pc_i, ex_valid_i, ex_pc_i, ex_imm_i,
    input  ex_branch_i, ex_alu_result_i,
    input  ex_pred_taken_i, ex_pred_target_i,
    output if_pred_taken_o, if_pred_target_o,
    output pc_imm_o, pc_four_o,
`ifdef BPU_STATS_EN
    output stat_branches_o, stat_mispred_o,
`endif
    output redirect_o, redirect_pc_o
  );

  modport master (
    output if_pc_i, ex_valid_i, ex_pc_i, ex_imm_i,
    output ex_branch_i, ex_alu_result_i,
    output ex_pred_taken_i, ex_pred_target_i,
    input  if_pred_taken_o, if_pred_target_o,
    input  pc_imm_o, pc_four_o,
`ifdef BPU_STATS_EN
    input  stat_branches_o, stat_mispred_o,
`endif
    input  redirect_o, redirect_pc_o
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped 2-bit branch predictor with target table and mispredict redirect.
// Ports: clk, rst_n (sync, active-low), bus (slave); macro BPU_STATS_EN adds stat counters.
module branch_predict_unit #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  branch_predict_unit_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [1:0]       ctr [ENTRIES];
  logic             vld [ENTRIES];
  logic [TAG_W-1:0] tag [ENTRIES];
  logic [31:0]      tgt [ENTRIES];

  logic             redirect;
  logic [31:0]      redirect_pc;

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_taken;
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic             e_hit;
  logic [31:0]      pc_ext;
  logic [31:0]      pc_imm;
  logic [31:0]      pc_four;
  logic             resolved;
  logic             taken;
  logic             mispred;

  assign f_idx   = bus.if_pc_i[IDX_W+1:2];
  assign f_tag   = bus.if_pc_i[PC_W-1:IDX_W+2];
  assign f_taken = vld[f_idx] && (tag[f_idx] == f_tag)
                   && ctr[f_idx][1];

  assign bus.if_pred_taken_o  = f_taken;
  assign bus.if_pred_target_o = f_taken ? tgt[f_idx] : 32'd0;

  assign pc_ext  = {{(32-PC_W){1'b0}}, bus.ex_pc_i};
  assign pc_imm  = pc_ext + bus.ex_imm_i;
  assign pc_four = pc_ext + 32'd4;

  assign bus.pc_imm_o  = pc_imm;
  assign bus.pc_four_o = pc_four;

  // ex inputs during a redirect cycle belong to the flushed wrong path
  assign resolved = bus.ex_valid_i && bus.ex_branch_i && !redirect;
  assign taken    = bus.ex_alu_result_i[0];
  assign mispred  = resolved &&
                    ((taken != bus.ex_pred_taken_i) ||
                     (taken && (bus.ex_pred_target_i != pc_imm)));

  assign e_idx = bus.ex_pc_i[IDX_W+1:2];
  assign e_tag = bus.ex_pc_i[PC_W-1:IDX_W+2];
  assign e_hit = vld[e_idx] && (tag[e_idx] == e_tag);

  assign bus.redirect_o    = redirect;
  assign bus.redirect_pc_o = redirect_pc;

  logic unused_bits;
  assign unused_bits = ^{bus.ex_alu_result_i[31:1], bus.if_pc_i[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= 2'd1;
        vld[i] <= 1'b0;
        tag[i] <= '0;
        tgt[i] <= '0;
      end
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect <= mispred;
      if (mispred)
        redirect_pc <= taken ? pc_imm : pc_four;
      if (resolved) begin
        if (e_hit) begin
          if (taken && ctr[e_idx] != 2'd3)
            ctr[e_idx] <= ctr[e_idx] + 2'd1;
          else if (!taken && ctr[e_idx] != 2'd0)
            ctr[e_idx] <= ctr[e_idx] - 2'd1;
        end else begin
          vld[e_idx] <= 1'b1;
          tag[e_idx] <= e_tag;
          ctr[e_idx] <= taken ? 2'd2 : 2'd1;
        end
        if (taken)
          tgt[e_idx] <= pc_imm;
      end
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] stat_br;
  logic [31:0] stat_mp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_br <= '0;
      stat_mp <= '0;
    end else begin
      if (resolved && stat_br != 32'hFFFF_FFFF)
        stat_br <= stat_br + 32'd1;
      if (mispred && stat_mp != 32'hFFFF_FFFF)
        stat_mp <= stat_mp + 32'd1;
    end
  end

  assign bus.stat_branches_o = stat_br;
  assign bus.stat_mispred_o  = stat_mp;
`endif
endmodule
